// File: rtl/cc_range_comparator_pkg.sv
// Purpose : shared encodings for the range comparator (compare modes, filter states).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: mode_e (EQ/NE/GT/LT), state_e (IDLE/ARMING/MATCHED), RESET_MODE.
package cc_range_comparator_pkg;

  typedef enum logic [1:0] {
    MODE_EQ = 2'b00,
    MODE_NE = 2'b01,
    MODE_GT = 2'b10,
    MODE_LT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMING  = 2'b01,
    ST_MATCHED = 2'b10
  } state_e;

  // NE against a zero threshold turns an unconfigured block into a nonzero detector.
  localparam mode_e RESET_MODE = MODE_NE;

endpackage

// File: rtl/cc_range_comparator_filter.sv
// Purpose : debounce filter; match asserts after FILTER_DEPTH consecutive qualifying edges.
// Latency : match is registered; rises on the FILTER_DEPTH-th consecutive qualifying edge.
// Backpressure: none; evaluates every clock.
//
// Ports: clk, rstN (async active-low), cond (qualifying this edge), restart (discard run),
//        match (registered, state==MATCHED), matchRise (comb: this edge enters MATCHED).
module cc_range_comparator_filter
  import cc_range_comparator_pkg::*;
#(
  parameter int FILTER_DEPTH = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic cond,
  input  logic restart,
  output logic match,
  output logic matchRise
);

  localparam int CW = $clog2(FILTER_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FILTER_DEPTH);
  // A depth-1 filter keeps no history, so there is nothing for a restart to discard;
  // this keeps match identical to the unfiltered result in that build.
  localparam bit HAS_HISTORY = (FILTER_DEPTH > 1);

  state_e        stateReg, stateNext;
  logic [CW-1:0] cntReg, cntNext;
  logic          restartEff;

  assign restartEff = restart & HAS_HISTORY;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg <= ST_IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    if (restartEff || !cond) begin
      stateNext = ST_IDLE;
      cntNext   = '0;
    end else if (cntReg == DEPTH_C) begin
      // saturated: hold in MATCHED for as long as the run lasts
      stateNext = ST_MATCHED;
    end else begin
      cntNext   = cntReg + CW'(1);
      stateNext = (cntNext == DEPTH_C) ? ST_MATCHED : ST_ARMING;
    end
  end

  assign match     = (stateReg == ST_MATCHED);
  assign matchRise = (stateNext == ST_MATCHED) && (stateReg != ST_MATCHED);

endmodule

// File: rtl/cc_range_comparator.sv
// Purpose : unsigned data-vs-threshold comparator with registered raw and filtered match.
// Latency : raw 1 edge after data; match after FILTER_DEPTH consecutive qualifying edges.
// Backpressure: none; one compare every clock.
//
// Ports: clock/reset, threshold load + value, 2-bit mode, data, sticky clear;
//        outputs raw, match, sticky.
// Build option: define CC_RANGECOMP_STICKY_EN to build the sticky match-history flag;
//        otherwise sticky is tied 0 and clear is ignored.
module cc_range_comparator
  import cc_range_comparator_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int FILTER_DEPTH = 4
) (
  input  logic                 CC_RANGECOMP_CLOCK_50,
  input  logic                 CC_RANGECOMP_RESET_InLow,
  input  logic                 CC_RANGECOMP_thr_load_InHigh,
  input  logic [DATAWIDTH-1:0] CC_RANGECOMP_thr_InBUS,
  input  logic [1:0]           CC_RANGECOMP_mode_InBUS,
  input  logic [DATAWIDTH-1:0] CC_RANGECOMP_data_InBUS,
  input  logic                 CC_RANGECOMP_clear_InHigh,
  output logic                 CC_RANGECOMP_raw_OutHigh,
  output logic                 CC_RANGECOMP_match_OutHigh,
  output logic                 CC_RANGECOMP_sticky_OutHigh
);

  logic [DATAWIDTH-1:0] thrReg;
  logic [1:0]           modeReg;
  logic                 cond;
  logic                 rawReg;
  logic                 modeChange;
  logic                 matchRise;

  // Compare against the stored threshold, so a load takes effect from the next edge.
  always_comb begin
    cond = 1'b0;
    case (mode_e'(CC_RANGECOMP_mode_InBUS))
      MODE_EQ: cond = (CC_RANGECOMP_data_InBUS == thrReg);
      MODE_NE: cond = (CC_RANGECOMP_data_InBUS != thrReg);
      MODE_GT: cond = (CC_RANGECOMP_data_InBUS >  thrReg);
      MODE_LT: cond = (CC_RANGECOMP_data_InBUS <  thrReg);
      default: cond = 1'b0;
    endcase
  end

  assign modeChange = (CC_RANGECOMP_mode_InBUS != modeReg);

  always_ff @(posedge CC_RANGECOMP_CLOCK_50 or negedge CC_RANGECOMP_RESET_InLow) begin
    if (!CC_RANGECOMP_RESET_InLow) begin
      thrReg  <= '0;
      modeReg <= RESET_MODE;
      rawReg  <= 1'b0;
    end else begin
      rawReg  <= cond;
      modeReg <= CC_RANGECOMP_mode_InBUS;
      if (CC_RANGECOMP_thr_load_InHigh) begin
        thrReg <= CC_RANGECOMP_thr_InBUS;
      end
    end
  end

  assign CC_RANGECOMP_raw_OutHigh = rawReg;

  cc_range_comparator_filter #(
    .FILTER_DEPTH(FILTER_DEPTH)
  ) uFilter (
    .clk      (CC_RANGECOMP_CLOCK_50),
    .rstN     (CC_RANGECOMP_RESET_InLow),
    .cond     (cond),
    .restart  (modeChange),
    .match    (CC_RANGECOMP_match_OutHigh),
    .matchRise(matchRise)
  );

`ifdef CC_RANGECOMP_STICKY_EN
  logic stickyReg;

  // A rising match beats a simultaneous clear.
  always_ff @(posedge CC_RANGECOMP_CLOCK_50 or negedge CC_RANGECOMP_RESET_InLow) begin
    if (!CC_RANGECOMP_RESET_InLow) begin
      stickyReg <= 1'b0;
    end else if (matchRise) begin
      stickyReg <= 1'b1;
    end else if (CC_RANGECOMP_clear_InHigh) begin
      stickyReg <= 1'b0;
    end
  end

  assign CC_RANGECOMP_sticky_OutHigh = stickyReg;
`else
  logic unusedStickyInputs;
  assign unusedStickyInputs          = CC_RANGECOMP_clear_InHigh ^ matchRise;
  assign CC_RANGECOMP_sticky_OutHigh = 1'b0;
`endif

endmodule

// File: tb/tb_cc_range_comparator.sv
// Purpose : self-checking bench; directed scenarios plus random stimulus vs a run-length model.
// Latency : n/a.
// Backpressure: n/a.
module tb_cc_range_comparator;

  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk;
  logic          rstN;
  logic          load;
  logic [DW-1:0] thr;
  logic [1:0]    mode;
  logic [DW-1:0] data;
  logic          clear;
  logic          raw, match, sticky;

  // second build: depth 1, 3-bit data
  logic       load1;
  logic [2:0] thr1;
  logic [1:0] mode1;
  logic [2:0] data1;
  logic       clear1;
  logic       raw1, match1, sticky1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] thrM;
  logic [1:0]    modeM;
  int            runLen;
  bit            rawM, matchM, stickyM;
  logic [2:0]    thr1M;
  bit            raw1M;

  cc_range_comparator #(.DATAWIDTH(DW), .FILTER_DEPTH(FD)) dut (
    .CC_RANGECOMP_CLOCK_50       (clk),
    .CC_RANGECOMP_RESET_InLow    (rstN),
    .CC_RANGECOMP_thr_load_InHigh(load),
    .CC_RANGECOMP_thr_InBUS      (thr),
    .CC_RANGECOMP_mode_InBUS     (mode),
    .CC_RANGECOMP_data_InBUS     (data),
    .CC_RANGECOMP_clear_InHigh   (clear),
    .CC_RANGECOMP_raw_OutHigh    (raw),
    .CC_RANGECOMP_match_OutHigh  (match),
    .CC_RANGECOMP_sticky_OutHigh (sticky)
  );

  cc_range_comparator #(.DATAWIDTH(3), .FILTER_DEPTH(1)) dutD1 (
    .CC_RANGECOMP_CLOCK_50       (clk),
    .CC_RANGECOMP_RESET_InLow    (rstN),
    .CC_RANGECOMP_thr_load_InHigh(load1),
    .CC_RANGECOMP_thr_InBUS      (thr1),
    .CC_RANGECOMP_mode_InBUS     (mode1),
    .CC_RANGECOMP_data_InBUS     (data1),
    .CC_RANGECOMP_clear_InHigh   (clear1),
    .CC_RANGECOMP_raw_OutHigh    (raw1),
    .CC_RANGECOMP_match_OutHigh  (match1),
    .CC_RANGECOMP_sticky_OutHigh (sticky1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit refCond(input logic [1:0] m, input int unsigned d, input int unsigned t);
    case (m)
      2'b00:   return d == t;
      2'b01:   return d != t;
      2'b10:   return d > t;
      default: return d < t;
    endcase
  endfunction

  task automatic modelReset();
    thrM    = '0;
    modeM   = 2'b01;
    runLen  = 0;
    rawM    = 0;
    matchM  = 0;
    stickyM = 0;
    thr1M   = '0;
    raw1M   = 0;
  endtask

  // Randomise the depth-1 instance's inputs; its match must track its raw result.
  task automatic randD1();
    load1  = ($urandom_range(0, 7) == 0);
    thr1   = 3'($urandom);
    mode1  = 2'($urandom);
    data1  = 3'($urandom);
    clear1 = 1'($urandom);
  endtask

  // One clock edge: predict from current inputs, advance the model, then check outputs.
  task automatic step();
    bit condM, cond1, modeChg, matchNew;
    condM   = refCond(mode, data, thrM);
    modeChg = (mode != modeM);
    cond1   = refCond(mode1, data1, thr1M);
    @(posedge clk);
    rawM = condM;
    if (modeChg)    runLen = 0;
    else if (condM) runLen = runLen + 1;
    else            runLen = 0;
    matchNew = (runLen >= FD);
`ifdef CC_RANGECOMP_STICKY_EN
    if (matchNew && !matchM) stickyM = 1;
    else if (clear)          stickyM = 0;
`else
    stickyM = 0;
`endif
    matchM = matchNew;
    if (load) thrM = thr;
    modeM = mode;
    raw1M = cond1;
    if (load1) thr1M = thr1;
    #1;
    chk("raw", raw, rawM);
    chk("match", match, matchM);
    chk("sticky", sticky, stickyM);
    chk("d1_raw", raw1, raw1M);
    chk("d1_match", match1, raw1M);
    chk("d1_sticky_off", sticky1, 0);
  endtask

  initial begin
    int expR[7] = '{0, 0, 1, 1, 1, 1, 0};
    int expM[7] = '{0, 0, 0, 0, 0, 1, 0};
    int dSeq[7] = '{0, 0, 5, 5, 5, 5, 0};

    rstN = 0; load = 0; thr = '0; mode = 2'b01; data = '0; clear = 0;
    randD1();
    modelReset();
    #1;
    chk("rst_raw", raw, 0);
    chk("rst_match", match, 0);
    chk("rst_sticky", sticky, 0);
    #11 rstN = 1;

    // nonzero detector straight out of reset
    for (int i = 0; i < 7; i++) begin
      data = DW'(dSeq[i]);
      randD1();
      step();
      chk("dflt_raw", raw, expR[i]);
      chk("dflt_match", match, expM[i]);
    end

    // GT against 0x80, then a long qualifying run
    load = 1; thr = 8'h80; mode = 2'b10; data = 8'h00; randD1(); step();
    load = 0;
    data = 8'h80; randD1(); step(); chk("gt_eq_raw", raw, 0);
    data = 8'h81; randD1(); step(); chk("gt_above_raw", raw, 1);
    data = 8'hFF;
    for (int i = 0; i < 10; i++) begin randD1(); step(); end
    chk("gt_sat_match", match, 1);

    // EQ run interrupted by a mode change to LT
    load = 1; thr = 8'h10; mode = 2'b00; data = 8'h10; randD1(); step();
    load = 0;
    for (int i = 0; i < 3; i++) begin randD1(); step(); end
    mode = 2'b11; data = 8'h05;
    for (int i = 0; i < 4; i++) begin
      randD1(); step();
      chk("modechg_match_low", match, 0);
    end
    randD1(); step();
    chk("modechg_match_high", match, 1);

    // async reset while matched
    rstN = 0; mode = 2'b01; data = 8'h05;
    #1;
    chk("arst_raw", raw, 0);
    chk("arst_match", match, 0);
    chk("arst_sticky", sticky, 0);
    chk("arst_d1_raw", raw1, 0);
    modelReset();
    @(negedge clk);
    rstN = 1;
    for (int i = 0; i < 3; i++) begin randD1(); step(); end
    chk("rearm_low", match, 0);
    randD1(); step();
    chk("rearm_high", match, 1);

    // sticky: clear coinciding with a new rise, then clear alone
    data = 8'h00; randD1(); step();
    data = 8'h05;
    for (int i = 0; i < 3; i++) begin randD1(); step(); end
    clear = 1; randD1(); step();
`ifdef CC_RANGECOMP_STICKY_EN
    chk("sticky_set_wins", sticky, 1);
`else
    chk("sticky_off", sticky, 0);
`endif
    randD1(); step();
    chk("sticky_cleared", sticky, 0);
    clear = 0;

    // random traffic on both instances
    for (int i = 0; i < 1000; i++) begin
      load  = ($urandom_range(0, 15) == 0);
      thr   = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      data  = DW'($urandom_range(0, 3));
      clear = ($urandom_range(0, 7) == 0);
      randD1();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_range_comparator.md
CC_RANGE_COMPARATOR -- requirements
Module: cc_range_comparator

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of the data and threshold buses (min 1).
REQ-002 Parameter FILTER_DEPTH, default 4, consecutive qualifying cycles required before match asserts (min 1).
REQ-003 CC_RANGECOMP_CLOCK_50  in  1  single clock, all state on rising edge.
REQ-004 CC_RANGECOMP_RESET_InLow  in  1  asynchronous, active-low reset.
REQ-005 CC_RANGECOMP_thr_load_InHigh  in  1  load strobe for the threshold register.
REQ-006 CC_RANGECOMP_thr_InBUS  in  DATAWIDTH  threshold value, captured when load is high.
REQ-007 CC_RANGECOMP_mode_InBUS  in  2  compare mode: 00 EQ, 01 NE, 10 GT, 11 LT (unsigned, data vs threshold).
REQ-008 CC_RANGECOMP_data_InBUS  in  DATAWIDTH  value under test.
REQ-009 CC_RANGECOMP_clear_InHigh  in  1  clears the sticky flag (sticky build only; ignored otherwise).
REQ-010 CC_RANGECOMP_raw_OutHigh  out  1  registered unfiltered compare result.
REQ-011 CC_RANGECOMP_match_OutHigh  out  1  filtered compare result.
REQ-012 CC_RANGECOMP_sticky_OutHigh  out  1  latched match history; tied 0 when feature is compiled out.

Function
REQ-013 The block SHALL evaluate cond = data (op mode) thr_reg combinationally, thr_reg being the stored threshold.
REQ-014 raw SHALL equal cond sampled at the previous rising edge (latency 1).
REQ-015 Threshold load: thr_reg <= thr_InBUS on an edge with load high; the compare at that same edge uses the old thr_reg, the new value from the next edge.
REQ-016 Filter counter cnt, width clog2(FILTER_DEPTH+1): per edge, cond=1 -> cnt <= min(cnt+1, FILTER_DEPTH); cond=0 -> cnt <= 0.
REQ-017 States: IDLE (cnt=0), ARMING (0<cnt<FILTER_DEPTH), MATCHED (cnt=FILTER_DEPTH); MATCHED holds while cond=1, any state -> IDLE on cond=0.
REQ-018 match SHALL be registered and equal 1 exactly when the state entered on that edge is MATCHED; asserts on the FILTER_DEPTH-th consecutive qualifying edge, deasserts on the first non-qualifying edge.
REQ-019 FILTER_DEPTH=1: match SHALL equal raw cycle-for-cycle.
REQ-020 Mode change: an edge where mode_InBUS differs from the mode sampled at the previous edge SHALL force cnt to 0 and match to 0 regardless of cond; raw is unaffected.
REQ-021 Counter saturates at FILTER_DEPTH; no wrap-around for arbitrarily long qualifying runs.
REQ-022 Simultaneous load and mode change: both take effect; counter restarts per REQ-020.

Reset
REQ-023 Reset low SHALL immediately force thr_reg=0, sampled mode=01 (NE), cnt=0, raw=0, match=0, sticky=0.
REQ-024 Reset asserted mid-run (ARMING or MATCHED) SHALL abort the run; after release counting restarts from IDLE.
REQ-025 Post-reset defaults (NE vs 0) SHALL make the block a registered nonzero detector without any configuration.

Configuration
REQ-026 Macro CC_RANGECOMP_STICKY_EN defined: sticky sets on the edge match rises, holds until an edge with clear high; set and clear on the same edge -> set wins.
REQ-027 Macro undefined: no sticky flop is built, sticky_OutHigh tied 0, clear ignored.

Structure
REQ-028 Package cc_range_comparator_pkg SHALL hold mode encodings (EQ/NE/GT/LT) and state encodings (IDLE/ARMING/MATCHED).
REQ-029 The counter/state logic SHALL be sub-module cc_range_comparator_filter (inputs cond, restart; output match); compare and threshold stay in the top.

Verification
REQ-030 Reset, no load, data 0,0,5,5,5,5,0 with FILTER_DEPTH=4: raw rises one edge after first 5; match high only after the 4th qualifying edge, drops on the edge sampling 0.
REQ-031 Load thr=0x80, mode GT: data 0x80 -> raw 0; data 0x81 -> raw 1; data 0xFF held 10 cycles -> match stays 1, no wrap.
REQ-032 Mode EQ, thr=0x10, data 0x10 for 3 edges then mode to LT while data 0x05: cnt restarts, match 0 for 4 further edges, then 1.
REQ-033 Reset pulsed low while match=1: all outputs 0 asynchronously (before next edge); re-arm needs full FILTER_DEPTH edges.
REQ-034 With CC_RANGECOMP_STICKY_EN: match pulse sets sticky; clear and new match rise on same edge -> sticky stays 1; clear alone -> 0. Without macro: sticky constant 0.
REQ-035 FILTER_DEPTH=1, DATAWIDTH=3 build: random data/mode for 1000 cycles -> match identical to raw every cycle.
